// File: rtl/my_mux_with_nands.sv
`default_nettype none
`timescale 1ns/1ps

// ============================================================================
// Module      : my_mux_with_nands_nand
// Description : N-input NAND cell with an optional simulation-only
//               propagation delay. Used as the only gate type in the mux
//               datapath.
// Ports       : in_i [N-1:0]  gate inputs
//               y_o           NAND of all inputs
// Revision    : 1.0  initial release
// ============================================================================
module my_mux_with_nands_nand #(
    parameter int N          = 2,
    parameter int GATE_DELAY = 0
) (
    input  logic [N-1:0] in_i,
    output logic         y_o
);

    // The zero-delay branch keeps the elaborated netlist free of timing
    // controls. Synthesis ignores the delayed form.
    generate
        if (GATE_DELAY == 0) begin : g_nodelay
            assign y_o = ~&in_i;
        end else begin : g_delay
            assign #(GATE_DELAY) y_o = ~&in_i;
        end
    endgenerate

endmodule

// ============================================================================
// Module      : my_mux_with_nands
// Description : 4-to-1 single-bit multiplexer built only from NAND cells,
//               with a combinational output and a registered copy.
// Ports       : clk    system clock, rising edge active
//               rst_n  asynchronous reset, active-low (clears w_q)
//               a..d   data inputs for {s1,s0} = 00, 01, 10, 11
//               s0,s1  select bits (s0 is the LSB)
//               w      combinational mux output
//               w_q    w registered on clk, one cycle latency
// Revision    : 1.0  initial release
// ============================================================================
module my_mux_with_nands #(
    parameter int GATE_DELAY = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic s0,
    input  logic s1,
    output logic w,
    output logic w_q
);

    logic w_ns0;
    logic w_ns1;
    logic w_t0;
    logic w_t1;
    logic w_t2;
    logic w_t3;
    logic w_q_d;

    // Level 1: select inverters, built as NANDs with tied inputs. These sit
    // on the worst-case path (select -> inverter -> product -> output).
    my_mux_with_nands_nand #(.N(2), .GATE_DELAY(GATE_DELAY)) u_ns0 (
        .in_i ({s0, s0}),
        .y_o  (w_ns0)
    );

    my_mux_with_nands_nand #(.N(2), .GATE_DELAY(GATE_DELAY)) u_ns1 (
        .in_i ({s1, s1}),
        .y_o  (w_ns1)
    );

    // Level 2: active-low product terms, one per data input. Only the term
    // matching the current select can go low, so unselected inputs (even X)
    // are masked by a known-0 select literal.
    my_mux_with_nands_nand #(.N(3), .GATE_DELAY(GATE_DELAY)) u_t0 (
        .in_i ({a, w_ns1, w_ns0}),
        .y_o  (w_t0)
    );

    my_mux_with_nands_nand #(.N(3), .GATE_DELAY(GATE_DELAY)) u_t1 (
        .in_i ({b, w_ns1, s0}),
        .y_o  (w_t1)
    );

    my_mux_with_nands_nand #(.N(3), .GATE_DELAY(GATE_DELAY)) u_t2 (
        .in_i ({c, s1, w_ns0}),
        .y_o  (w_t2)
    );

    my_mux_with_nands_nand #(.N(3), .GATE_DELAY(GATE_DELAY)) u_t3 (
        .in_i ({d, s1, s0}),
        .y_o  (w_t3)
    );

    // Level 3: NAND of active-low terms is the OR of the products.
    my_mux_with_nands_nand #(.N(4), .GATE_DELAY(GATE_DELAY)) u_out (
        .in_i ({w_t0, w_t1, w_t2, w_t3}),
        .y_o  (w)
    );

    assign w_q_d = w;

    // Output register: the only state in the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q <= 1'b0;
        end else begin
            w_q <= w_q_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_my_mux_with_nands.sv
`default_nettype none
`timescale 1ns/1ps

// ============================================================================
// Module      : tb_my_mux_with_nands
// Description : Directed bench for my_mux_with_nands. One zero-delay
//               instance for function and register checks, one instance
//               with GATE_DELAY=10 for propagation timing.
// Revision    : 1.0  initial release
// ============================================================================
module tb_my_mux_with_nands;

    logic clk;
    logic rst_n;
    logic a, b, c, d, s0, s1;
    logic w, w_q;

    logic da, db, dc, dd, ds0, ds1;
    logic dw, dw_q;

    int n_checks;
    int n_errors;

    my_mux_with_nands #(.GATE_DELAY(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .s0    (s0),
        .s1    (s1),
        .w     (w),
        .w_q   (w_q)
    );

    my_mux_with_nands #(.GATE_DELAY(10)) dut_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (da),
        .b     (db),
        .c     (dc),
        .d     (dd),
        .s0    (ds0),
        .s1    (ds1),
        .w     (dw),
        .w_q   (dw_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        a = 1'b1; b = 1'b0; c = 1'b0; d = 1'b0; s1 = 1'b0; s0 = 1'b0;
        #1;
        n_checks++;
        if (w_q !== 1'b0) begin
            $display("FAIL reset_wq: got %b want 0", w_q);
            n_errors++;
        end
        @(posedge clk); #1;
        n_checks++;
        if (w_q !== 1'b0) begin
            $display("FAIL reset_hold_wq: got %b want 0", w_q);
            n_errors++;
        end
        n_checks++;
        if (w !== 1'b1) begin
            $display("FAIL reset_w_comb: got %b want 1", w);
            n_errors++;
        end
    endtask

    task automatic test_unselected();
        a = 1'b0; b = 1'b1; c = 1'b1; d = 1'b1; s1 = 1'b1; s0 = 1'b1;
        #1;
        n_checks++;
        if (w !== 1'b1) begin
            $display("FAIL unsel_d: got %b want 1", w);
            n_errors++;
        end
        a = 1'b1;
        #1;
        n_checks++;
        if (w !== 1'b1) begin
            $display("FAIL unsel_a_change: got %b want 1", w);
            n_errors++;
        end
        // X on an unselected input must not leak through.
        a = 1'bx; b = 1'bx; c = 1'bx; d = 1'b0;
        #1;
        n_checks++;
        if (w !== 1'b0) begin
            $display("FAIL unsel_x: got %b want 0", w);
            n_errors++;
        end
    endtask

    task automatic test_select_toggle();
        a = 1'b1; b = 1'b0; c = 1'b0; d = 1'b0; s1 = 1'b0; s0 = 1'b0;
        #1;
        n_checks++;
        if (w !== 1'b1) begin
            $display("FAIL toggle_sel00: got %b want 1", w);
            n_errors++;
        end
        s0 = 1'b1;
        #1;
        n_checks++;
        if (w !== 1'b0) begin
            $display("FAIL toggle_sel01: got %b want 0", w);
            n_errors++;
        end
        s0 = 1'b0;
        #1;
        n_checks++;
        if (w !== 1'b1) begin
            $display("FAIL toggle_back00: got %b want 1", w);
            n_errors++;
        end
    endtask

    task automatic test_sweep();
        logic [5:0] v;
        logic       exp;
        for (int i = 0; i < 64; i++) begin
            v = i[5:0];
            {a, b, c, d, s1, s0} = v;
            case (v[1:0])
                2'b00:   exp = v[5];
                2'b01:   exp = v[4];
                2'b10:   exp = v[3];
                default: exp = v[2];
            endcase
            #1;
            n_checks++;
            if (w !== exp) begin
                $display("FAIL sweep_%0d: got %b want %b", i, w, exp);
                n_errors++;
            end
        end
    endtask

    task automatic test_async_reset();
        rst_n = 1'b1;
        a = 1'b1; b = 1'b0; c = 1'b0; d = 1'b0; s1 = 1'b0; s0 = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (w_q !== 1'b1) begin
            $display("FAIL arst_pre: got %b want 1", w_q);
            n_errors++;
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (w_q !== 1'b0) begin
            $display("FAIL arst_immediate: got %b want 0", w_q);
            n_errors++;
        end
        #1 rst_n = 1'b1;
        #1;
        n_checks++;
        if (w_q !== 1'b0) begin
            $display("FAIL arst_release_noedge: got %b want 0", w_q);
            n_errors++;
        end
        @(posedge clk); #1;
        n_checks++;
        if (w_q !== 1'b1) begin
            $display("FAIL arst_first_capture: got %b want 1", w_q);
            n_errors++;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_seq;
        logic       prev;
        exp_seq = 4'b1010;   // w for sel 00,01,10,11 with a..d = 1,0,1,0
        a = 1'b1; b = 1'b0; c = 1'b1; d = 1'b0;
        s1 = 1'b1; s0 = 1'b1;  // park on d=0 so the first step is visible
        @(posedge clk); #1;
        prev = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            {s1, s0} = k[1:0];
            #1;
            n_checks++;
            if (w !== exp_seq[3-k]) begin
                $display("FAIL b2b_w_%0d: got %b want %b", k, w, exp_seq[3-k]);
                n_errors++;
            end
            n_checks++;
            if (w_q !== prev) begin
                $display("FAIL b2b_latency_%0d: got %b want %b", k, w_q, prev);
                n_errors++;
            end
            @(posedge clk); #1;
            n_checks++;
            if (w_q !== exp_seq[3-k]) begin
                $display("FAIL b2b_wq_%0d: got %b want %b", k, w_q, exp_seq[3-k]);
                n_errors++;
            end
            prev = exp_seq[3-k];
        end
    endtask

    task automatic test_gate_delay();
        logic [3:0] data;
        // Data step with selects held: two NAND levels, 20 ns.
        for (int k = 0; k < 4; k++) begin
            data = 4'b0000;
            {da, db, dc, dd} = data;
            {ds1, ds0} = k[1:0];
            #100;
            n_checks++;
            if (dw !== 1'b0) begin
                $display("FAIL dly_settle_%0d: got %b want 0", k, dw);
                n_errors++;
            end
            data[3-k] = 1'b1;
            {da, db, dc, dd} = data;
            #19;
            n_checks++;
            if (dw !== 1'b0) begin
                $display("FAIL dly_data_early_%0d: got %b want 0", k, dw);
                n_errors++;
            end
            #2;
            n_checks++;
            if (dw !== 1'b1) begin
                $display("FAIL dly_data_20ns_%0d: got %b want 1", k, dw);
                n_errors++;
            end
        end
        // Select step on s1: a=0, c=1, so w rises 0 -> 1 within 30 ns.
        da = 1'b0; db = 1'b0; dc = 1'b1; dd = 1'b0; ds1 = 1'b0; ds0 = 1'b0;
        #100;
        n_checks++;
        if (dw !== 1'b0) begin
            $display("FAIL dly_sel_settle: got %b want 0", dw);
            n_errors++;
        end
        ds1 = 1'b1;
        #19;
        n_checks++;
        if (dw !== 1'b0) begin
            $display("FAIL dly_sel_early: got %b want 0", dw);
            n_errors++;
        end
        #12;
        n_checks++;
        if (dw !== 1'b1) begin
            $display("FAIL dly_sel_30ns: got %b want 1", dw);
            n_errors++;
        end
        // Worst-case falling path on s0: a=1,b=0, sel 00 -> 01.
        da = 1'b1; db = 1'b0; dc = 1'b0; dd = 1'b0; ds1 = 1'b0; ds0 = 1'b0;
        #100;
        ds0 = 1'b1;
        #31;
        n_checks++;
        if (dw !== 1'b0) begin
            $display("FAIL dly_s0_fall_30ns: got %b want 0", dw);
            n_errors++;
        end
        ds0 = 1'b0;
        #31;
        n_checks++;
        if (dw !== 1'b1) begin
            $display("FAIL dly_s0_rise_30ns: got %b want 1", dw);
            n_errors++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        a = 1'b0; b = 1'b0; c = 1'b0; d = 1'b0; s0 = 1'b0; s1 = 1'b0;
        da = 1'b0; db = 1'b0; dc = 1'b0; dd = 1'b0; ds0 = 1'b0; ds1 = 1'b0;

        test_reset();
        test_unselected();
        test_select_toggle();
        test_sweep();
        test_async_reset();
        test_back_to_back();
        test_gate_delay();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/my_mux_with_nands.md
Name: my_mux_with_nands

Overview:
- 4-to-1 single-bit multiplexer whose combinational datapath uses only NAND gates. No AND, OR, NOT or conditional operators appear in the datapath.
- Provides a combinational output and a registered copy of it, clocked by the system clock.
- Used as a gate-level teaching and timing block: worst-case select transitions exercise the full NAND depth.

Parameters:
- GATE_DELAY, 0: simulation-only propagation delay, in ns, applied to every NAND instance. 0 means zero delay. It has no effect in synthesis.

Ports:
- clk  input  1  system clock; rising edge active.
- rst_n  input  1  asynchronous reset, active-low.
- a  input  1  data input selected when {s1,s0}=2'b00.
- b  input  1  data input selected when {s1,s0}=2'b01.
- c  input  1  data input selected when {s1,s0}=2'b10.
- d  input  1  data input selected when {s1,s0}=2'b11.
- s0  input  1  select bit, LSB.
- s1  input  1  select bit, MSB.
- w  output  1  combinational mux output.
- w_q  output  1  registered mux output.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Function: w = a when {s1,s0}=00, b when 01, c when 10, d when 11.
- Required NAND structure, with each level delayed by GATE_DELAY:
  - Level 1: ns0 = NAND(s0,s0) and ns1 = NAND(s1,s1).
  - Level 2, product terms:
    - t0 = NAND(a,ns1,ns0)
    - t1 = NAND(b,ns1,s0)
    - t2 = NAND(c,s1,ns0)
    - t3 = NAND(d,s1,s0)
  - Level 3: w = NAND(t0,t1,t2,t3).
  - Worst-case path is a select bit through its inverter: 3·GATE_DELAY.
  - Data-to-output path: 2·GATE_DELAY.
- Implement the 3- and 4-input NANDs as dedicated NAND primitives or NAND-only submodules. Do not decompose them into AND/OR.
- w is purely combinational. It is not affected by clk or rst_n.
- w_q:
  - Asynchronously cleared to 0 while rst_n=0.
  - On each rising clk edge with rst_n=1, w_q takes the current value of w.
  - Latency is 1 cycle.
- Reset release is synchronous to clk as seen by w_q: the first capture occurs at the first rising edge after rst_n goes high.
- Unknown inputs: if the selected data input or any select bit is X, w may be X. Unselected inputs at X must not corrupt w when the selects are known, which holds naturally for the NAND form.
- Hazards: a static-1 glitch on w during a single-select-bit toggle is permitted when the two selected inputs are equal. w must settle within 3·GATE_DELAY. w_q samples only after settling and is glitch-free.
- No state other than the w_q flop.

Test Plan:
- a=0,b=1,c=1,d=1,s1=1,s0=1 -> w=1 (selects d). Change a to 1 -> w stays 1 (unselected input is ignored).
- a=1,b=0,c=0,d=0,s1=0,s0=0 -> w=1. Toggle s0 to 1 -> w=0 within 3·GATE_DELAY (worst-case falling transition). Toggle s0 back to 0 -> w=1 within 3·GATE_DELAY (worst-case rising transition).
- Exhaustive sweep of all 64 combinations of {a,b,c,d,s1,s0} -> w equals the selected input in every case.
- rst_n=0 asserted mid-cycle while w=1 -> w_q goes to 0 immediately, without waiting for a clock edge. Release rst_n -> w_q=1 after the next rising clk edge.
- Drive s1:s0 = 00,01,10,11 on successive cycles with a,b,c,d = 1,0,1,0 -> w_q sequence 1,0,1,0, each value delayed one cycle from w.
- Set GATE_DELAY=10 and step each data input with its selects held -> w changes 20 ns later. Step s1 -> w changes no later than 30 ns.
